// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 mux datapath.
// It grants one requester at a time, registers its data with a valid strobe and caps each grant at MAX_HOLD transfers.
module mux_rr_arbiter #(
    parameter int unsigned DW       = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic [DW-1:0] y,
    output logic          valid,
    output logic          busy
);

    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state, state_n;
    logic [1:0]    ptr, ptr_n;
    logic [1:0]    sel_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    gnt_n;
    logic [DW-1:0] y_n;
    logic          valid_n;
    logic          busy_n;
    logic [1:0]    winner;
    logic [1:0]    idx;
    logic          found;
    logic [DW-1:0] mux_data;

    // The first requester found when scanning upward from ptr wins.
    always_comb begin
        winner = ptr;
        idx    = ptr;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    mux_data = din0;
            2'd1:    mux_data = din1;
            2'd2:    mux_data = din2;
            default: mux_data = din3;
        endcase
    end

    assign cnt_inc = cnt + CW'(1);

    // Next-state logic. A release is handled inline so that the hold-limit
    // release shares the edge with the final transfer.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        cnt_n   = cnt;
        gnt_n   = gnt;
        y_n     = y;
        valid_n = 1'b0;
        busy_n  = busy;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_n = GRANT;
                    sel_n   = winner;
                    gnt_n   = 4'b0001 << winner;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                end
            end
            GRANT: begin
                if (req[sel]) begin
                    y_n     = mux_data;
                    valid_n = 1'b1;
                    cnt_n   = cnt_inc;
                end
                if (!req[sel] || (cnt_inc == CW'(MAX_HOLD))) begin
                    state_n = IDLE;
                    gnt_n   = 4'b0000;
                    busy_n  = 1'b0;
                    ptr_n   = sel + 2'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel   <= 2'd0;
            cnt   <= '0;
            gnt   <= 4'b0000;
            y     <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            y     <= y_n;
            valid <= valid_n;
            busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a vector table on a MAX_HOLD=8 instance,
// plus a full-contention sequence on a MAX_HOLD=3 instance.
module tb_mux_rr_arbiter;

    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [DW-1:0] dv [4];

    logic [3:0]    gnt8, gnt3;
    logic [1:0]    sel8, sel3;
    logic [DW-1:0] y8, y3;
    logic          valid8, valid3, busy8, busy3;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.DW(DW), .MAX_HOLD(8)) u_dut8 (
        .clk(clk), .rst(rst), .req(req),
        .din0(dv[0]), .din1(dv[1]), .din2(dv[2]), .din3(dv[3]),
        .gnt(gnt8), .sel(sel8), .y(y8), .valid(valid8), .busy(busy8)
    );

    mux_rr_arbiter #(.DW(DW), .MAX_HOLD(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req),
        .din0(dv[0]), .din1(dv[1]), .din2(dv[2]), .din3(dv[3]),
        .gnt(gnt3), .sel(sel3), .y(y3), .valid(valid3), .busy(busy3)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [3:0] y;
        logic       valid;
        logic       busy;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input string name, input logic r, input logic [3:0] q,
                       input logic [3:0] g, input logic [1:0] s, input logic [3:0] yy,
                       input logic v, input logic b);
        vec_t e;
        e.name = name; e.rst = r; e.req = q; e.gnt = g; e.sel = s;
        e.y = yy; e.valid = v; e.busy = b;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
    task automatic step(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    localparam logic [3:0] DA = 4'hA, DB = 4'hB, D2 = 4'h1, DC = 4'hC;

    initial begin
        logic [3:0] oh;
        logic [3:0] exp_y;
        int         g;

        rst = 1'b1;
        req = 4'b0000;
        dv[0] = DA; dv[1] = DB; dv[2] = D2; dv[3] = DC;

        // reset, then first grant goes to 0
        add("rst_a",         1, 4'b1111, 4'b0000, 0, 4'h0, 0, 0);
        add("rst_b",         1, 4'b1111, 4'b0000, 0, 4'h0, 0, 0);
        add("rst_first_gnt", 0, 4'b1111, 4'b0001, 0, 4'h0, 0, 1);
        add("drop0",         0, 4'b0000, 4'b0000, 0, 4'h0, 0, 0);
        // single requester 2, four transfers
        add("single_arb",    0, 4'b0100, 4'b0100, 2, 4'h0, 0, 1);
        for (int i = 0; i < 4; i++)
            add("single_xfer", 0, 4'b0100, 4'b0100, 2, D2, 1, 1);
        add("single_rel",    0, 4'b0000, 4'b0000, 2, D2, 0, 0);
        add("ptr3_arb",      0, 4'b1111, 4'b1000, 3, D2, 0, 1);
        // pointer wrap
        add("g3_xfer",       0, 4'b1000, 4'b1000, 3, DC, 1, 1);
        add("g3_rel",        0, 4'b0011, 4'b0000, 3, DC, 0, 0);
        add("wrap_to0",      0, 4'b0011, 4'b0001, 0, DC, 0, 1);
        add("g0_xfer",       0, 4'b0011, 4'b0001, 0, DA, 1, 1);
        add("g0_rel",        0, 4'b0010, 4'b0000, 0, DA, 0, 0);
        add("g1_arb",        0, 4'b0010, 4'b0010, 1, DA, 0, 1);
        add("g1_xfer",       0, 4'b0010, 4'b0010, 1, DB, 1, 1);
        add("g1_rel",        0, 4'b1001, 4'b0000, 1, DB, 0, 0);
        add("skip0_to3",     0, 4'b1001, 4'b1000, 3, DB, 0, 1);
        // immediate drop by requester 1
        add("g3_drop",       0, 4'b0010, 4'b0000, 3, DB, 0, 0);
        add("g1b_arb",       0, 4'b0010, 4'b0010, 1, DB, 0, 1);
        add("imm_drop",      0, 4'b0000, 4'b0000, 1, DB, 0, 0);
        add("ptr2_arb",      0, 4'b1111, 4'b0100, 2, DB, 0, 1);
        // reset during the second transfer of requester 2
        add("g2_xfer1",      0, 4'b0100, 4'b0100, 2, D2, 1, 1);
        add("rst_mid",       1, 4'b0100, 4'b0000, 0, 4'h0, 0, 0);
        add("post_rst_arb",  0, 4'b0101, 4'b0001, 0, 4'h0, 0, 1);
        // full hold of 8 transfers, release on the last one
        for (int i = 0; i < 7; i++)
            add("hold_xfer", 0, 4'b0101, 4'b0001, 0, DA, 1, 1);
        add("hold_last",     0, 4'b0101, 4'b0000, 0, DA, 1, 0);
        add("hold_next",     0, 4'b0101, 4'b0100, 2, DA, 0, 1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req);
            chk({vecs[i].name, ".gnt"},   int'(gnt8),   int'(vecs[i].gnt));
            chk({vecs[i].name, ".sel"},   int'(sel8),   int'(vecs[i].sel));
            chk({vecs[i].name, ".y"},     int'(y8),     int'(vecs[i].y));
            chk({vecs[i].name, ".valid"}, int'(valid8), int'(vecs[i].valid));
            chk({vecs[i].name, ".busy"},  int'(busy8),  int'(vecs[i].busy));
        end

        // full contention on the MAX_HOLD=3 instance: order 0,1,2,3,0
        step(1, 4'b1111);
        chk("cont_rst.gnt", int'(gnt3), 0);
        for (int gi = 0; gi < 5; gi++) begin
            g  = gi % 4;
            oh = 4'b0001 << g;
            step(0, 4'b1111);
            chk($sformatf("cont%0d_arb.gnt", gi),   int'(gnt3),   int'(oh));
            chk($sformatf("cont%0d_arb.sel", gi),   int'(sel3),   g);
            chk($sformatf("cont%0d_arb.valid", gi), int'(valid3), 0);
            for (int t = 0; t < 3; t++) begin
                for (int k = 0; k < 4; k++) dv[k] = 4'($urandom_range(0, 15));
                exp_y = dv[g];
                step(0, 4'b1111);
                chk($sformatf("cont%0d_x%0d.valid", gi, t), int'(valid3), 1);
                chk($sformatf("cont%0d_x%0d.y", gi, t),     int'(y3),     int'(exp_y));
                chk($sformatf("cont%0d_x%0d.gnt", gi, t),   int'(gnt3),   (t < 2) ? int'(oh) : 0);
                chk($sformatf("cont%0d_x%0d.busy", gi, t),  int'(busy3),  (t < 2) ? 1 : 0);
                chk($sformatf("cont%0d_x%0d.sel", gi, t),   int'(sel3),   g);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the shared 4:1 mux datapath. Four requesters compete for the single mux output. The block grants one requester at a time and drives the mux select. It registers the selected data with a valid strobe and bounds each grant with a hold limit so no requester can starve the others.

## Interface
- `DW`, default 1 — width of each data input and of `y`
- `MAX_HOLD`, default 8 — maximum transfers per grant; legal range 1..255
- `clk` in 1 — single clock, rising-edge
- `rst` in 1 — synchronous, active-high reset
- `req` in 4 — request lines; `req[i]` belongs to requester i
- `din0`..`din3` in `DW` each — requester data, mux inputs I0..I3
- `gnt` out 4 — one-hot grant, all zero when no grant
- `sel` out 2 — mux select {S1,S0}; equals the index of the granted requester
- `y` out `DW` — registered mux output
- `valid` out 1 — `y` holds a transfer made on the preceding edge
- `busy` out 1 — high while in GRANT

## Operation
- **Two states.**
  - IDLE: `gnt`=0, `busy`=0.
  - GRANT: `gnt`=onehot(`sel`), `busy`=1.
- **Round-robin pointer.** `ptr` is 2 bits and is reset to 0.
  - Search order is `ptr`, `ptr`+1, `ptr`+2, `ptr`+3, taken mod 4.
  - The winner is the first index in that order with `req` high.
- **IDLE, on an edge:**
  - If `req`≠0: state becomes GRANT, `sel` is the winner, `gnt` is onehot(winner), `cnt` is 0.
  - If `req`=0: remain in IDLE.
- **GRANT, on an edge:**
  - If `req[sel]`=0, release with no transfer.
  - Otherwise transfer: `y` ← `din[sel]`, `valid` ← 1, `cnt` ← `cnt`+1.
  - If `cnt`+1 = `MAX_HOLD`, the same edge also releases after that transfer.
- **Release:**
  - State becomes IDLE, `gnt` ← 0, `ptr` ← `sel`+1 mod 4 (3 wraps to 0).
  - `sel` holds its last value while in IDLE.
- **`valid`:**
  - It is 1 only in the cycle following a transfer edge; 0 otherwise.
  - `y` holds its last value when `valid`=0.
- **Widths:**
  - `cnt` is `$clog2(MAX_HOLD+1)` bits.
  - `sel`+1 wraps mod 4.
  - Requests from non-granted requesters are ignored until the next IDLE arbitration.
- **Request edges:**
  - A requester that drops `req` and re-raises it while still granted keeps the grant only if `req` was high at every GRANT edge.
  - A single low sample releases the grant.
- **Reset:**
  - `rst` overrides everything, including a grant in progress.
  - Next cycle: state IDLE, `gnt`=0, `sel`=0, `ptr`=0, `cnt`=0, `y`=0, `valid`=0, `busy`=0.

## Timing
- **Arbitration latency.** `req` is sampled high in IDLE at edge k. `gnt`/`sel` are valid after edge k, and the first transfer is at edge k+1. The first `valid`=1 appears in the cycle after k+1.
- **Grant duration.** Full hold gives `MAX_HOLD` consecutive `valid` cycles. `gnt` drops on the same edge as the last transfer.
- **Mandatory IDLE gap.** Every grant is followed by at least one cycle with `gnt`=0, the arbitration cycle. Back-to-back requesters therefore see a gap of 1 cycle between grants.
- **Throughput.** With all four requesting, the maximum is `MAX_HOLD` transfers per `MAX_HOLD`+1 cycles.
- **Data path.** `din` is sampled on the transfer edge. `y` has one cycle of latency from `din`.
- **Simultaneous events:**
  - Release and new requests on the same edge: no grant on that edge; arbitration happens next edge using the updated `ptr`.
  - `rst` with any other event: reset wins.

## Test plan
1. **Reset values.** Assert `rst` for 2 cycles with `req`=4'b1111 → `gnt`=0, `sel`=0, `y`=0, `valid`=0, `busy`=0 throughout; the first grant after release is to 0.
2. **Single requester.** `MAX_HOLD`=8; `req`=4'b0100 for 4 cycles after grant; `din2`=1 → `gnt`=4'b0100, `sel`=2, `valid` high for exactly 4 cycles with `y`=1; then IDLE and `ptr`=3.
3. **Full contention.** `MAX_HOLD`=3; `req`=4'b1111 held → grant order 0,1,2,3,0; each grant gives 3 `valid` cycles; 1 IDLE cycle between grants; `sel` matches `gnt` each time.
4. **Pointer wrap.** Grant to 3 ends, then `req`=4'b0011 → grant goes to 0. A later grant to 1 ends with `req`=4'b1001 → grant goes to 3, not 0.
5. **Immediate drop.** Requester 1 is granted but `req[1]`=0 at the first GRANT edge → zero transfers, `valid` never asserts, `ptr`=2.
6. **Reset mid-grant.** Assert `rst` during the 2nd transfer of requester 2 → next cycle `gnt`=0, `valid`=0, `y`=0, `ptr`=0; with `req`=4'b0101 the next grant is to 0.
